// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // Width of one carry-lookahead slice; each pipeline stage adds one slice.
    localparam int SLICE_W = 4;

    // Number of pipeline stages needed to cover an operand of the given width.
    function automatic int calc_stages(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/carry_lookahead_4bit.sv
// Purely combinational 4-bit carry-lookahead slice: generate/propagate terms
// give every internal carry in two gate levels instead of a ripple chain.
module carry_lookahead_4bit
    import cla_pkg::*;
(
    output logic               Cout,
    output logic [SLICE_W-1:0] S,
    input  logic [SLICE_W-1:0] X,
    input  logic [SLICE_W-1:0] Y,
    input  logic               Cin
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W:0]   w_c;

    assign w_p = X ^ Y;
    assign w_g = X & Y;

    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & Cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign S    = w_p ^ w_c[SLICE_W-1:0];
    assign Cout = w_c[SLICE_W];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit adder: one 4-bit carry-lookahead slice per stage, the
// carry handed from stage to stage through a register. Operands travel down
// the pipe alongside the partial sum so each stage finds its slice in place.
// The whole pipe advances as one unit under a valid/ready handshake.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int STAGES = calc_stages(WIDTH);

    // Stage registers (index k = stage k).
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_cy;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_x   [STAGES];
    logic [WIDTH-1:0]  r_y   [STAGES];

    // What each stage sees at its input, and what its slice produces.
    logic [STAGES-1:0]  w_vld_in;
    logic [STAGES-1:0]  w_cy_in;
    logic [STAGES-1:0]  w_cy_out;
    logic [WIDTH-1:0]   w_sum_in [STAGES];
    logic [WIDTH-1:0]   w_x_in   [STAGES];
    logic [WIDTH-1:0]   w_y_in   [STAGES];
    logic [SLICE_W-1:0] w_s      [STAGES];

    logic w_adv;

    // The pipe only moves when the output slot is empty or being drained,
    // so a stalled consumer freezes every stage and no bubble is squeezed.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    // Reset empties the pipe, so the input side is offered as ready then
    // (whatever is presented is discarded by the reset branch below).
    assign in_ready = w_adv || rst;

    // Stage k adds operand bits [4k+3:4k] using the carry registered by stage k-1.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_vld_in[k] = in_valid;
            assign w_cy_in[k]  = Cin;
            assign w_sum_in[k] = '0;
            assign w_x_in[k]   = X;
            assign w_y_in[k]   = Y;
        end else begin : g_next
            assign w_vld_in[k] = r_vld[k-1];
            assign w_cy_in[k]  = r_cy[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_x_in[k]   = r_x[k-1];
            assign w_y_in[k]   = r_y[k-1];
        end

        carry_lookahead_4bit u_cla (
            .Cout (w_cy_out[k]),
            .S    (w_s[k]),
            .X    (w_x_in[k][SLICE_W*k +: SLICE_W]),
            .Y    (w_y_in[k][SLICE_W*k +: SLICE_W]),
            .Cin  (w_cy_in[k])
        );
    end

    // Shift all stages together on advance; reset clears valid, carry and sum state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_cy  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vld_in[k];
                r_cy[k]  <= w_cy_out[k];
                r_sum[k] <= w_sum_in[k]
                          | ({{(WIDTH-SLICE_W){1'b0}}, w_s[k]} << (SLICE_W*k));
                r_x[k]   <= w_x_in[k];
                r_y[k]   <= w_y_in[k];
            end
        end
    end

    // Final stage holds the completed result.
    assign out_valid = r_vld[STAGES-1];
    assign S         = r_sum[STAGES-1];
    assign Cout      = r_cy[STAGES-1];

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant: STAGES = WIDTH/4, the pipeline depth in cycles.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  the operand set X/Y/Cin is valid this cycle.
REQ-006 Port: in_ready  output  1  the block accepts the operand set this cycle.
REQ-007 Port: X  input  WIDTH  addend A.
REQ-008 Port: Y  input  WIDTH  addend B.
REQ-009 Port: Cin  input  1  carry-in to bit 0.
REQ-010 Port: out_valid  output  1  S/Cout hold a valid result.
REQ-011 Port: out_ready  input  1  the downstream stage consumes the result this cycle.
REQ-012 Port: S  output  WIDTH  sum.
REQ-013 Port: Cout  output  1  carry-out of the MSB.

Function
REQ-014 The block SHALL compute {Cout,S} = X + Y + Cin with full WIDTH+1-bit precision and no saturation.
REQ-015 Stage k (k = 0..STAGES-1) SHALL add operand bits [4k+3:4k] with one 4-bit carry-lookahead slice, using the carry registered by stage k-1 (Cin for stage 0).
REQ-016 Each stage SHALL register: a valid bit, the carry-out of its slice, the sum bits completed so far, and the operand bits not yet added (skew/deskew registers).
REQ-017 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, when out_ready is held high.
REQ-018 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-019 Advance enable: adv = !out_valid || out_ready; all stages SHALL shift together only when adv=1, and SHALL hold all contents otherwise.
REQ-020 in_ready SHALL equal adv, combinationally, with no dependency on in_valid.
REQ-021 When adv=1 and in_valid=0, stage 0 SHALL load a bubble (valid=0); bubbles SHALL propagate and be squeezed out only by normal shifting.
REQ-022 While out_valid=1 and out_ready=0, S, Cout and out_valid SHALL remain stable.
REQ-023 Output handshake: a transfer occurs on a cycle with out_valid && out_ready.
REQ-024 Wrap-around: a sum of 2^WIDTH or more SHALL wrap S modulo 2^WIDTH and set Cout=1.
REQ-025 Input values presented while in_ready=0 SHALL be ignored.

Reset
REQ-026 When rst=1 at a clock edge, all stage valid bits SHALL clear to 0, and S, Cout and all carry/sum registers SHALL clear to 0.
REQ-027 Reset mid-operation SHALL discard every in-flight result; no result accepted before reset SHALL ever appear on the output.
REQ-028 During the rst=1 cycle, in_ready SHALL be driven to 1 (out_valid is 0); inputs presented in that cycle SHALL be discarded.
REQ-029 Rst SHALL take priority over adv.

Structure
REQ-030 Shared package cla_pkg SHALL hold the constant SLICE_W=4 and the function computing STAGES from WIDTH.
REQ-031 The existing carry_lookahead_4bit module (ports Cout, S, X, Y, Cin) SHALL be instantiated STAGES times, one per stage.
REQ-032 No other sub-modules SHALL be used; all registers SHALL reside in cla_pipe_adder.

Verification (WIDTH=16, STAGES=4)
REQ-033 X=0x1234, Y=0x4321, Cin=0, out_ready=1 -> 4 cycles after acceptance: out_valid=1, S=0x5555, Cout=0.
REQ-034 X=0xFFFF, Y=0x0000, Cin=1 -> S=0x0000, Cout=1 (full carry ripple across all stages).
REQ-035 Back-to-back inputs 0x0001+0x0001, then 0x8000+0x8000, then 0x7FFF+0x0001, with out_ready=1 -> results on consecutive cycles: 0x0002/0, 0x0000/1, 0x8000/0.
REQ-036 Three results in flight, then out_ready=0 for 5 cycles -> in_ready=0 while the output stage is full, S held constant, no result lost or duplicated; after out_ready returns to 1, results emerge in order.
REQ-037 Two inputs accepted, rst=1 for one cycle at cycle 2 -> out_valid stays 0 for the next 6 cycles and neither result appears.
REQ-038 Exhaustive low-slice sweep: X[3:0], Y[3:0] over 0..15 and Cin over 0..1 with random upper bits, streamed at full rate -> all 512 results match the reference sum, with a pass count of 512.
